// File: rtl/lstm_init_loader_if.sv
// Parameter-load bus between the byte source / LSTM core side and the init loader.
interface lstm_init_loader_if;
   logic        iStart;
   logic        iByte_valid;
   logic [7:0]  iByte_data;
   logic        oByte_ready;
   logic        oInit_valid;
   logic [2:0]  oInit_type;
   logic [7:0]  oInit_data;
   logic        oBusy;
   logic        oDone;
   logic [15:0] oLoad_count;

   modport master (
      output iStart, iByte_valid, iByte_data,
      input  oByte_ready, oInit_valid, oInit_type, oInit_data, oBusy, oDone, oLoad_count
   );

   modport slave (
      input  iStart, iByte_valid, iByte_data,
      output oByte_ready, oInit_valid, oInit_type, oInit_data, oBusy, oDone, oLoad_count
   );
endinterface

// File: rtl/lstm_init_loader.sv
// Replays a flat byte stream onto the LSTM init port as six typed segments,
// each followed by a fixed idle gap.
module lstm_init_loader #(
   parameter int unsigned SYS_W_LEN  = 512,
   parameter int unsigned SYS_B_LEN  = 32,
   parameter int unsigned BR_W_LEN   = 32768,
   parameter int unsigned BR_B_LEN   = 256,
   parameter int unsigned CONV_W_LEN = 1024,
   parameter int unsigned CONV_B_LEN = 128,
   parameter int unsigned GAP_CYCLES = 10
) (
   input logic             clk,
   input logic             resetn,
   lstm_init_loader_if.slave ldr
);

   typedef enum logic [1:0] {StIdle, StLoad, StGap, StDone} state_e;

   localparam logic [15:0] GapLast = 16'(GAP_CYCLES - 1);

   state_e      state_q, state_d;
   logic [2:0]  seg_q, seg_d;
   logic [15:0] cnt_q, cnt_d;
   logic        init_valid_q, init_valid_d;
   logic [2:0]  init_type_q, init_type_d;
   logic [7:0]  init_data_q, init_data_d;
   logic [15:0] seg_len;
   logic [15:0] seg_last;
   logic        accept;

   always_comb begin
      case (seg_q)
         3'd0:    seg_len = 16'(SYS_W_LEN);
         3'd1:    seg_len = 16'(SYS_B_LEN);
         3'd2:    seg_len = 16'(BR_W_LEN);
         3'd3:    seg_len = 16'(BR_B_LEN);
         3'd4:    seg_len = 16'(CONV_W_LEN);
         default: seg_len = 16'(CONV_B_LEN);
      endcase
   end

   assign seg_last = seg_len - 16'd1;
   // Ready is decoded from state alone so the source never sees a combinational loop.
   assign accept   = (state_q == StLoad) && ldr.iByte_valid;

   always_comb begin
      state_d      = state_q;
      seg_d        = seg_q;
      cnt_d        = cnt_q;
      init_valid_d = 1'b0;
      init_type_d  = 3'd7;
      init_data_d  = init_data_q;
      case (state_q)
         StIdle, StDone: begin
            if (ldr.iStart) begin
               state_d = StLoad;
               seg_d   = 3'd0;
               cnt_d   = 16'd0;
            end
         end
         StLoad: begin
            init_type_d = seg_q;
            if (accept) begin
               init_valid_d = 1'b1;
               init_data_d  = ldr.iByte_data;
               if (cnt_q == seg_last) begin
                  state_d = StGap;
                  cnt_d   = 16'd0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         StGap: begin
            if (cnt_q == GapLast) begin
               cnt_d = 16'd0;
               if (seg_q < 3'd5) begin
                  seg_d   = seg_q + 3'd1;
                  state_d = StLoad;
               end else begin
                  state_d = StDone;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= StIdle;
         seg_q        <= 3'd0;
         cnt_q        <= 16'd0;
         init_valid_q <= 1'b0;
         init_type_q  <= 3'd7;
         init_data_q  <= 8'd0;
      end else begin
         state_q      <= state_d;
         seg_q        <= seg_d;
         cnt_q        <= cnt_d;
         init_valid_q <= init_valid_d;
         init_type_q  <= init_type_d;
         init_data_q  <= init_data_d;
      end
   end

   assign ldr.oByte_ready = (state_q == StLoad);
   assign ldr.oInit_valid = init_valid_q;
   assign ldr.oInit_type  = init_type_q;
   assign ldr.oInit_data  = init_data_q;
   assign ldr.oBusy       = (state_q == StLoad) || (state_q == StGap);
   assign ldr.oDone       = (state_q == StDone);
   assign ldr.oLoad_count = (state_q == StLoad) ? cnt_q : 16'd0;

endmodule
